// File: rtl/arb_rr_lock.sv
// rtl/arb_rr_lock.sv - round-robin packet arbiter with lock-until-last and registered output stage
// Optional packet counter output cnt enabled by ARB_RR_LOCK_STAT_EN.
module arb_rr_lock #(
  parameter type DAT_T = logic [4-1:0],
  parameter int  WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  DAT_T [WIDTH-1:0]         ary,
  input  logic [WIDTH-1:0]         lst,
  output logic [WIDTH-1:0]         rdy,
  output logic                     vld,
  output DAT_T                     dat,
  output logic                     last,
  output logic [$clog2(WIDTH)-1:0] idx,
  input  logic                     acc
`ifdef ARB_RR_LOCK_STAT_EN
  ,
  output logic [15:0]              cnt
`endif
);

  localparam int IW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_width_chk
    $fatal(1, "arb_rr_lock: WIDTH must be >= 2");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n, own, own_n;
  logic [IW-1:0] win, sel, sel_inc;
  logic          free, xfer;

  // First requester at or after p, wrapping; descending scan lets the nearest one win.
  function automatic logic [IW-1:0] rr_pick(input logic [WIDTH-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    logic [IW-1:0] jj;
    int            j;
    w = p;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= WIDTH) j = j - WIDTH;
      jj = IW'(j);
      if (r[jj]) w = jj;
    end
    return w;
  endfunction

  always_comb begin
    free    = ~vld | acc;
    win     = rr_pick(req, ptr);
    sel     = (state == LOCK) ? own : win;
    sel_inc = (sel == IW'(WIDTH - 1)) ? '0 : sel + 1'b1;
    rdy     = '0;
    state_n = state;
    ptr_n   = ptr;
    own_n   = own;
    case (state)
      IDLE:    if (free && (|req)) rdy[win] = 1'b1;
      LOCK:    rdy[own] = free;
      default: rdy = '0;
    endcase
    if (rst) rdy = '0;
    xfer = |(req & rdy);
    if (xfer) begin
      if (lst[sel]) begin
        state_n = IDLE;
        ptr_n   = sel_inc;
      end else begin
        state_n = LOCK;
        own_n   = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      own   <= own_n;
    end
  end

  // A new beat always wins over draining, giving one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      dat  <= '0;
      last <= 1'b0;
      idx  <= '0;
    end else if (xfer) begin
      vld  <= 1'b1;
      dat  <= ary[sel];
      last <= lst[sel];
      idx  <= sel;
    end else if (acc) begin
      vld  <= 1'b0;
    end
  end

`ifdef ARB_RR_LOCK_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (vld && acc && last) cnt <= cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_arb_rr_lock.sv
// tb/tb_arb_rr_lock.sv - randomized and directed bench for arb_rr_lock against a packet-level model
module tb_arb_rr_lock;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [3:0][3:0] ary = '0;
  logic [3:0]      lst = '0;
  logic [3:0]      rdy;
  logic            vld;
  logic [3:0]      dat;
  logic            last;
  logic [1:0]      idx;
  logic            acc = 1'b1;
`ifdef ARB_RR_LOCK_STAT_EN
  logic [15:0]     cnt;
`endif

  arb_rr_lock #(.DAT_T(logic [3:0]), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ary(ary), .lst(lst), .rdy(rdy),
    .vld(vld), .dat(dat), .last(last), .idx(idx), .acc(acc)
`ifdef ARB_RR_LOCK_STAT_EN
    , .cnt(cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner < 0 means no packet in progress.
  int         m_own;
  int         m_ptr;
  bit         m_vld;
  logic [3:0] m_dat;
  bit         m_last;
  int         m_idx;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_vld = 0; m_dat = '0; m_last = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    check("vld", 32'(vld), 32'(m_vld));
    check("dat", 32'(dat), 32'(m_dat));
    check("last", 32'(last), 32'(m_last));
    check("idx", 32'(idx), m_idx);
`ifdef ARB_RR_LOCK_STAT_EN
    check("cnt", 32'(cnt), m_cnt & 32'hFFFF);
`endif
  endtask

  // Called just after a negedge; returns after the following negedge.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic a);
    int         win;
    logic [3:0] er;
    bit         fr;
    int         j;
    req = r; lst = l; acc = a;
    ary = 16'($urandom);
    #1;
    fr  = !m_vld || a;
    er  = '0;
    win = -1;
    if (m_own < 0) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (win < 0 && r[j]) win = j;
      end
      if (!fr) win = -1;
    end else begin
      win = m_own;
      if (!fr) win = -1;
    end
    if (win >= 0) er[win] = 1'b1;
    check("rdy", 32'(rdy), 32'(er));
    @(posedge clk);
    if (m_vld && a && m_last) m_cnt++;
    if (win >= 0 && r[win]) begin
      m_vld = 1; m_dat = ary[win]; m_last = l[win]; m_idx = win;
      if (l[win]) begin
        m_own = -1;
        m_ptr = (win + 1) % 4;
      end else begin
        m_own = win;
      end
    end else if (a) begin
      m_vld = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous pulse landing mid-cycle, checked before any clock edge.
  task automatic pulse_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_rdy", 32'(rdy), 32'd0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single-beat packets from all requesters rotate 0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b1111, 1'b1);
      check("seq_idx", 32'(idx), k % 4);
    end

    // 3-beat packet from 0 holds off requester 1.
    pulse_reset();
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b1);
    check("pkt_idx0", 32'(idx), 32'd0);
    step(4'b0010, 4'b0010, 1'b1);
    check("pkt_idx1", 32'(idx), 32'd1);

    // Output stall then resume.
    step(4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) step(4'b1111, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b1111, 4'b1111, 1'b1);

    // Pointer wrap: ptr=3, req=0101 -> grant 0 then 2.
    pulse_reset();
    step(4'b0100, 4'b0100, 1'b1);
    step(4'b0101, 4'b1111, 1'b1);
    check("wrap_g0", 32'(idx), 32'd0);
    step(4'b0101, 4'b1111, 1'b1);
    check("wrap_g2", 32'(idx), 32'd2);

    // Reset mid-packet with owner 2, then lowest requester wins.
    pulse_reset();
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    pulse_reset();
    step(4'b1110, 4'b1111, 1'b1);
    check("post_rst_idx", 32'(idx), 32'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
